xnor_cmp_sched: RTL

XNOR_CMP_SCHED -- requirements
Module: xnor_cmp_sched

---
 rtl/xnor_cmp_sched.sv | 122 ++++++++++++
 1 files changed

// File: rtl/xnor_cmp_sched.sv
// xnor_cmp_sched -- two-requester bit-serial equality/match-count comparator.
// A single 1-bit XNOR cell is time-shared between two requesters. The
// winner's operands are captured, then compared one bit per cycle, LSB
// first, for 8 cycles. Arbitration is round-robin on the last-served id.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   req0, req1       compare requests, held high until the matching gnt
//   a0, b0, a1, b1   8-bit operand pairs of requester 0 / 1
//   gnt0, gnt1       one-cycle grant pulse (operands captured)
//   busy             high while a compare is in flight (SHIFT or DONE)
//   done             one-cycle result-valid pulse
//   done_id          requester served by the current result
//   eq               all 8 bit pairs match
//   match_cnt        number of matching bit positions, 0..8
module xnor_cmp_sched (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] a0,
   input  logic [7:0] b0,
   input  logic [7:0] a1,
   input  logic [7:0] b1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       busy,
   output logic       done,
   output logic       done_id,
   output logic       eq,
   output logic [3:0] match_cnt
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t     state, state_nx;
   logic [7:0] sh_a, sh_b;
   logic [2:0] bit_cnt;
   logic [3:0] acc;
   logic [3:0] acc_nx;
   logic       last_id;
   logic       cur_id;
   logic       capture;
   logic       win_id;
   logic       xnor_bit;

   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      win_id   = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               capture  = 1'b1;
               // On a tie the requester not served last wins.
               win_id   = (req0 && req1) ? ~last_id : req1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_cnt == 3'd7) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign xnor_bit = sh_a[0] ~^ sh_b[0];
   // At most 8 increments from zero, so the 4-bit sum cannot wrap.
   assign acc_nx   = acc + {3'b000, xnor_bit};
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a      <= '0;
         sh_b      <= '0;
         bit_cnt   <= '0;
         acc       <= '0;
         last_id   <= 1'b1;
         cur_id    <= 1'b0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done      <= 1'b0;
         done_id   <= 1'b0;
         eq        <= 1'b0;
         match_cnt <= '0;
      end else begin
         gnt0 <= capture && !win_id;
         gnt1 <= capture &&  win_id;
         done <= 1'b0;
         if (capture) begin
            sh_a    <= win_id ? a1 : a0;
            sh_b    <= win_id ? b1 : b0;
            bit_cnt <= '0;
            acc     <= '0;
            last_id <= win_id;
            cur_id  <= win_id;
         end
         if (state == SHIFT) begin
            acc     <= acc_nx;
            sh_a    <= {1'b0, sh_a[7:1]};
            sh_b    <= {1'b0, sh_b[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            // Results are registered from the bit-7 sum so they are valid
            // in the same cycle done is high.
            if (bit_cnt == 3'd7) begin
               done      <= 1'b1;
               done_id   <= cur_id;
               match_cnt <= acc_nx;
               eq        <= (acc_nx == 4'd8);
            end
         end
      end
   end

endmodule
